// File: rtl/multicycle_risc_core_if.sv
// rtl/multicycle_risc_core_if.sv - control handshake and instruction-fetch bus of the multicycle core
// Signals:
//   start          host -> core  1-cycle pulse, begin execution at PC=0 (idle/halted only)
//   imem_addr      core -> host  instruction word address (=PC)
//   imem_rdata     host -> core  instruction word, combinational response to imem_addr
//   busy           core -> host  instruction in flight (FETCH..WB)
//   halted         core -> host  core sits in HALT
//   illegal        core -> host  sticky unknown opcode/funct flag
//   instr_retired  core -> host  1-cycle pulse on the last cycle of each instruction
// Modports: master = core side, slave = host/ROM side.
interface multicycle_risc_core_if #(
  parameter int PC_W = 8
);
  logic            start;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            busy;
  logic            halted;
  logic            illegal;
  logic            instr_retired;

  modport master (
    input  start, imem_rdata,
    output imem_addr, busy, halted, illegal, instr_retired
  );

  modport slave (
    output start, imem_rdata,
    input  imem_addr, busy, halted, illegal, instr_retired
  );
endinterface

// File: rtl/multicycle_risc_core.sv
// rtl/multicycle_risc_core.sv - multi-cycle MIPS-style core with internal register file and data memory
// Ports:
//   clk                    rising-edge clock
//   rst                    asynchronous active-high reset
//   bus                    multicycle_risc_core_if.master (start/busy/halted/illegal/retire, imem fetch)
//   probe_reg_sel_i        register index to observe
//   probe_mem_sel_i        data-memory index to observe
//   probe_register_file_o  rf[probe_reg_sel_i], combinational
//   probe_data_memory_o    dmem[probe_mem_sel_i], combinational
module multicycle_risc_core #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int DMEM_AW = 5,
  parameter int PC_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  multicycle_risc_core_if.master    bus,
  input  logic [REG_AW-1:0]         probe_reg_sel_i,
  input  logic [DMEM_AW-1:0]        probe_mem_sel_i,
  output logic [DATA_W-1:0]         probe_register_file_o,
  output logic [DATA_W-1:0]         probe_data_memory_o
);
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_BEQ = 6'b000100, OP_HALT = 6'b111111;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q;
  logic [31:0]         ir_q;
  logic [DATA_W-1:0]   a_q, b_q, alu_q, mdr_q;
  logic                illegal_q;
  logic                retired;
  logic [DATA_W-1:0]   rf_q   [2**REG_AW];
  logic [DATA_W-1:0]   dmem_q [2**DMEM_AW];

  logic [5:0]          op, funct;
  logic [REG_AW-1:0]   rs_a, rt_a, rd_a, wb_a;
  logic                is_r, is_lw, is_sw, is_addi, is_beq, is_halt, r_ok, legal;
  logic [DATA_W-1:0]   imm_ext, alu_b, alu_res, wb_data;
  logic [5:0]          alu_fn;
  logic [DMEM_AW-1:0]  mem_a;
  logic                unused_shamt;

  assign op      = ir_q[31:26];
  assign funct   = ir_q[5:0];
  assign rs_a    = ir_q[21 +: REG_AW];
  assign rt_a    = ir_q[16 +: REG_AW];
  assign rd_a    = ir_q[11 +: REG_AW];
  assign imm_ext = DATA_W'($signed(ir_q[15:0]));
  assign unused_shamt = ^ir_q[10:6];

  assign is_r    = (op == OP_R);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_addi = (op == OP_ADDI);
  assign is_beq  = (op == OP_BEQ);
  assign is_halt = (op == OP_HALT);
  assign r_ok    = is_r && (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                            funct == FN_OR  || funct == FN_SLT);
  assign legal   = r_ok || is_lw || is_sw || is_addi || is_beq || is_halt;

  // Single shared ALU: BEQ compares by subtraction, address/ADDI use the immediate.
  assign alu_b  = (is_r || is_beq) ? b_q : imm_ext;
  assign alu_fn = is_r ? funct : (is_beq ? FN_SUB : FN_ADD);
  always_comb begin
    alu_res = a_q + alu_b;
    case (alu_fn)
      FN_SUB:  alu_res = a_q - alu_b;
      FN_AND:  alu_res = a_q & alu_b;
      FN_OR:   alu_res = a_q | alu_b;
      FN_SLT:  alu_res = DATA_W'($signed(a_q) < $signed(alu_b));
      default: alu_res = a_q + alu_b;
    endcase
  end

  assign mem_a   = alu_q[DMEM_AW-1:0];
  assign wb_a    = is_r ? rd_a : rt_a;
  assign wb_data = is_lw ? mdr_q : alu_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    retired = 1'b0;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (is_halt) state_d = S_HALT;
        else if (!legal) begin
          state_d = S_FETCH;
          retired = 1'b1;
        end else state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_beq) begin
          state_d = S_FETCH;
          retired = 1'b1;
        end else if (is_lw || is_sw) state_d = S_MEM;
        else state_d = S_WB;
      end
      S_MEM: begin
        if (is_sw) begin
          state_d = S_FETCH;
          retired = 1'b1;
        end else state_d = S_WB;
      end
      S_WB: begin
        state_d = S_FETCH;
        retired = 1'b1;
      end
      S_HALT:   if (bus.start) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 2**REG_AW; i++)  rf_q[i]   <= DATA_W'(i);
      for (int i = 0; i < 2**DMEM_AW; i++) dmem_q[i] <= DATA_W'(i);
    end else begin
      case (state_q)
        S_IDLE, S_HALT: if (bus.start) begin
          pc_q      <= '0;
          illegal_q <= 1'b0;
        end
        S_FETCH: begin
          ir_q <= bus.imem_rdata;
          pc_q <= pc_q + 1'b1;
        end
        S_DECODE: begin
          a_q <= rf_q[rs_a];
          b_q <= rf_q[rt_a];
          if (!legal) illegal_q <= 1'b1;
        end
        S_EXEC: begin
          alu_q <= alu_res;
          // pc_q already holds PC+1 here
          if (is_beq && alu_res == '0) pc_q <= pc_q + ir_q[PC_W-1:0];
        end
        S_MEM: begin
          if (is_sw) dmem_q[mem_a] <= b_q;
          else       mdr_q         <= dmem_q[mem_a];
        end
        S_WB: if (wb_a != '0) rf_q[wb_a] <= wb_data;
        default: ;
      endcase
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.busy          = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted        = (state_q == S_HALT);
  assign bus.illegal       = illegal_q;
  assign bus.instr_retired = retired;

  assign probe_register_file_o = rf_q[probe_reg_sel_i];
  assign probe_data_memory_o   = dmem_q[probe_mem_sel_i];
endmodule

// File: tb/tb_multicycle_risc_core.sv
// tb/tb_multicycle_risc_core.sv - directed-vector bench for multicycle_risc_core
module tb_multicycle_risc_core;
  logic        clk;
  logic        rst;
  logic [4:0]  probe_reg_sel;
  logic [4:0]  probe_mem_sel;
  logic [31:0] probe_rf;
  logic [31:0] probe_dm;
  logic [31:0] rom [256];
  int          n_vec = 0;
  int          n_err = 0;
  int          retire_cnt = 0;

  multicycle_risc_core_if #(.PC_W(8)) bus ();

  multicycle_risc_core #(.DATA_W(32), .REG_AW(5), .DMEM_AW(5), .PC_W(8)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .bus                   (bus),
    .probe_reg_sel_i       (probe_reg_sel),
    .probe_mem_sel_i       (probe_mem_sel),
    .probe_register_file_o (probe_rf),
    .probe_data_memory_o   (probe_dm)
  );

  assign bus.imem_rdata = rom[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.instr_retired) retire_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    rtype = {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input int imm);
    itype = {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic reg_is(input string tag, input int idx, input logic [31:0] exp);
    probe_reg_sel = 5'(idx);
    #1;
    chk(tag, probe_rf, exp);
  endtask

  task automatic mem_is(input string tag, input int idx, input logic [31:0] exp);
    probe_mem_sel = 5'(idx);
    #1;
    chk(tag, probe_dm, exp);
  endtask

  // Walk one instruction from its FETCH cycle; retire must pulse on its last cycle.
  task automatic run_instr(input string tag, input int lat);
    repeat (lat - 1) tick();
    chk({tag, "_retire"}, bus.instr_retired, 1);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hFC00_0000;
    rom[0]  = itype(6'b100011, 2, 1, 3);        // LW   r1,3(r2)
    rom[1]  = itype(6'b101011, 8, 1, 1);        // SW   r1,1(r8)
    rom[2]  = rtype(3, 4, 1, 6'b100000);        // ADD  r1,r3,r4
    rom[3]  = rtype(10, 8, 1, 6'b100010);       // SUB  r1,r10,r8
    rom[4]  = itype(6'b000100, 3, 3, 2);        // BEQ  r3,r3,+2
    rom[5]  = itype(6'b001000, 0, 7, 99);       // ADDI r7,r0,99 (skipped)
    rom[6]  = itype(6'b001000, 0, 7, 98);       // skipped
    rom[7]  = itype(6'b001000, 0, 5, -1);       // ADDI r5,r0,-1
    rom[8]  = rtype(5, 0, 6, 6'b101010);        // SLT  r6,r5,r0
    rom[9]  = rtype(3, 4, 0, 6'b100000);        // ADD  r0,r3,r4
    rom[10] = itype(6'b000100, 3, 4, 5);        // BEQ  r3,r4,+5 (not taken)
    rom[11] = 32'h5400_0000;                    // op 010101 illegal
    rom[12] = rtype(11, 11, 11, 6'b100000);     // ADD  r11,r11,r11
    rom[13] = rtype(13, 14, 12, 6'b100100);     // AND  r12,r13,r14
    rom[14] = rtype(16, 3, 15, 6'b100101);      // OR   r15,r16,r3
    rom[15] = 32'hFC00_0000;                    // HALT

    rst = 1'b1;
    bus.start = 1'b0;
    probe_reg_sel = '0;
    probe_mem_sel = '0;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_retired", bus.instr_retired, 0);
    chk("rst_pc", bus.imem_addr, 0);
    reg_is("rst_rf0", 0, 0);
    reg_is("rst_rf3", 3, 3);
    mem_is("rst_dm9", 9, 9);
    rst = 1'b0;
    tick();
    chk("idle_busy", bus.busy, 0);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy", bus.busy, 1);
    chk("start_pc", bus.imem_addr, 0);

    run_instr("lw", 5);
    reg_is("lw_rf1", 1, 5);
    chk("lw_retcnt", retire_cnt, 1);
    chk("lw_pc", bus.imem_addr, 1);

    run_instr("sw", 4);
    mem_is("sw_dm9", 9, 5);
    run_instr("add", 4);
    reg_is("add_rf1", 1, 7);
    run_instr("sub", 4);
    reg_is("sub_rf1", 1, 2);

    chk("beq_t_pc0", bus.imem_addr, 4);
    run_instr("beq_t", 3);
    chk("beq_t_pc", bus.imem_addr, 7);
    reg_is("beq_skip_rf7", 7, 7);

    run_instr("addi", 4);
    reg_is("addi_rf5", 5, 32'hFFFF_FFFF);
    run_instr("slt", 4);
    reg_is("slt_rf6", 6, 1);
    run_instr("add_r0", 4);
    reg_is("add_r0_rf0", 0, 0);

    run_instr("beq_nt", 3);
    chk("beq_nt_pc", bus.imem_addr, 11);

    run_instr("illegal", 2);
    chk("ill_flag", bus.illegal, 1);
    chk("ill_pc", bus.imem_addr, 12);

    run_instr("add_same", 4);
    reg_is("add_same_rf11", 11, 22);
    run_instr("and", 4);
    reg_is("and_rf12", 12, 12);
    run_instr("or", 4);
    reg_is("or_rf15", 15, 19);

    tick();
    chk("halt_retired", bus.instr_retired, 0);
    tick();
    chk("halt_halted", bus.halted, 1);
    chk("halt_busy", bus.busy, 0);
    chk("halt_illegal_sticky", bus.illegal, 1);
    tick();
    tick();
    chk("halt_stays", bus.halted, 1);
    chk("halt_retcnt", retire_cnt, 13);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart_pc", bus.imem_addr, 0);
    chk("restart_illegal", bus.illegal, 0);
    chk("restart_halted", bus.halted, 0);
    chk("restart_busy", bus.busy, 1);
    reg_is("restart_rf1_kept", 1, 2);

    tick();                 // DECODE of LW
    bus.start = 1'b1;       // ignored while busy
    tick();                 // EXEC
    bus.start = 1'b0;
    tick();                 // MEM
    tick();                 // WB
    chk("busy_start_retire", bus.instr_retired, 1);
    tick();
    chk("busy_start_pc", bus.imem_addr, 1);
    reg_is("relw_rf1", 1, 5);

    tick();
    tick();
    tick();                 // MEM of SW r1,1(r8)
    chk("sw_mem_retire", bus.instr_retired, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_pc", bus.imem_addr, 0);
    tick();
    rst = 1'b0;
    tick();
    mem_is("abort_dm9", 9, 9);
    reg_is("abort_rf1", 1, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_halted", bus.halted, 0);
    chk("abort_pc", bus.imem_addr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
